fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 23 ++
 rtl/fetch_unit_pc_next.sv | 30 +++
 rtl/fetch_unit.sv | 147 ++++++++++++++
 tb/tb_fetch_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared widths, parameter defaults and encodings for the instruction fetch unit.
package fetch_unit_pkg;
  localparam int OP_W   = 4;
  localparam int RS_W   = 2;
  localparam int ADDR_W = 8;

  localparam logic [OP_W-1:0] HALT_OP_DEF      = 4'h1;
  localparam logic [15:0]     LONG_OP_MASK_DEF = 16'hF000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_t;

  // PC_SEQ steps by the length of the instruction currently at PC
  typedef enum logic [1:0] {
    PC_HOLD  = 2'd0,
    PC_SEQ   = 2'd1,
    PC_PLUS1 = 2'd2,
    PC_REDIR = 2'd3
  } pc_sel_t;
endpackage

// File: rtl/fetch_unit_pc_next.sv
// Combinational next-PC selector (redirect / +1 / +2 / hold) with end-of-memory
// detection for a two-byte instruction sitting at the last address.
module fetch_pc_next
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0] LONG_OP_MASK = LONG_OP_MASK_DEF
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [OP_W-1:0]   op,
  input  pc_sel_t           sel,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [ADDR_W-1:0] pc_next,
  output logic              end_fault
);
  logic long_op;

  assign long_op   = LONG_OP_MASK[op];
  assign end_fault = long_op && (pc == {ADDR_W{1'b1}});

  always_comb begin
    pc_next = pc;
    unique case (sel)
      PC_HOLD:  pc_next = pc;
      PC_SEQ:   pc_next = pc + (long_op ? 8'd2 : 8'd1);
      PC_PLUS1: pc_next = pc + 8'd1;
      PC_REDIR: pc_next = redirect_addr;
      default:  pc_next = pc;
    endcase
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC, single instruction register with valid/ready handoff,
// redirect and halt handling. Define FETCH_PERF_EN to add issue/stall counters.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC     = 8'h00,
  parameter logic [15:0]       LONG_OP_MASK = LONG_OP_MASK_DEF,
  parameter logic [OP_W-1:0]   HALT_OP      = HALT_OP_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [OP_W-1:0]   imem_op,
  input  logic [RS_W-1:0]   imem_ra,
  input  logic [RS_W-1:0]   imem_rb,
  input  logic              imem_brx,
  input  logic [ADDR_W-1:0] imem_ea,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [OP_W-1:0]   ir_op,
  output logic [RS_W-1:0]   ir_ra,
  output logic [RS_W-1:0]   ir_rb,
  output logic              ir_brx,
  output logic [ADDR_W-1:0] ir_ea,
  output logic [ADDR_W-1:0] ir_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              halted,
  output logic              fault
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]       perf_issued,
  output logic [15:0]       perf_stall
`endif
);
  fetch_state_t      state, state_nx;
  pc_sel_t           pc_sel;
  logic [ADDR_W-1:0] pc, pc_next;
  logic              end_fault;
  logic              load, clr_valid, set_fault, ir_take;

  assign imem_addr = pc;
  assign halted    = (state == ST_HALT);
  assign ir_take   = ir_valid && ir_ready;

  fetch_pc_next #(
    .LONG_OP_MASK(LONG_OP_MASK)
  ) u_pc_next (
    .pc           (pc),
    .op           (imem_op),
    .sel          (pc_sel),
    .redirect_addr(redirect_addr),
    .pc_next      (pc_next),
    .end_fault    (end_fault)
  );

  always_comb begin
    state_nx  = state;
    pc_sel    = PC_HOLD;
    load      = 1'b0;
    clr_valid = 1'b0;
    set_fault = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (run) state_nx = ST_FETCH;
      end
      ST_FETCH: begin
        if (redirect_valid) begin
          pc_sel    = PC_REDIR;
          clr_valid = 1'b1;
        end else if (!ir_valid || ir_ready) begin
          if (end_fault) begin
            // Two-byte opcode with no byte left for its ea: refuse it and stop
            set_fault = 1'b1;
            clr_valid = ir_take;
            state_nx  = ST_HALT;
          end else begin
            load = 1'b1;
            if (imem_op == HALT_OP) state_nx = ST_HALT;
            else                    pc_sel   = PC_SEQ;
          end
        end
      end
      ST_HALT: begin
        if (redirect_valid) begin
          pc_sel    = PC_REDIR;
          clr_valid = 1'b1;
          state_nx  = ST_FETCH;
        end else begin
          clr_valid = ir_take;
          if (run) begin
            pc_sel   = PC_PLUS1;
            state_nx = ST_FETCH;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pc       <= RESET_PC;
      fault    <= 1'b0;
      ir_valid <= 1'b0;
      ir_op    <= '0;
      ir_ra    <= '0;
      ir_rb    <= '0;
      ir_brx   <= 1'b0;
      ir_ea    <= '0;
      ir_pc    <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_next;
      fault <= fault | set_fault;
      if (load) begin
        ir_valid <= 1'b1;
        ir_op    <= imem_op;
        ir_ra    <= imem_ra;
        ir_rb    <= imem_rb;
        ir_brx   <= imem_brx;
        ir_ea    <= imem_ea;
        ir_pc    <= pc;
      end else if (clr_valid) begin
        ir_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (ir_valid && ir_ready)  perf_issued <= sat_inc(perf_issued);
      if (ir_valid && !ir_ready) perf_stall  <= sat_inc(perf_stall);
    end
  end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit against a small byte-wide instruction memory model.
module tb_fetch_unit;
  logic       clk = 1'b0;
  logic       rst_n, run, ir_ready, redirect_valid;
  logic [7:0] redirect_addr, imem_addr, imem_ea, ir_ea, ir_pc;
  logic [3:0] imem_op, ir_op;
  logic [1:0] imem_ra, imem_rb, ir_ra, ir_rb;
  logic       imem_brx, ir_brx, ir_valid, halted, fault;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_issued, perf_stall;
`endif

  logic [7:0] mem [256];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Byte layout: op[7:4] ra[3:2] rb[1:0], brx = bit 2; ea is the following byte
  assign imem_op  = mem[imem_addr][7:4];
  assign imem_ra  = mem[imem_addr][3:2];
  assign imem_rb  = mem[imem_addr][1:0];
  assign imem_brx = mem[imem_addr][2];
  assign imem_ea  = mem[imem_addr + 8'd1];

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .run(run), .imem_addr(imem_addr),
    .imem_op(imem_op), .imem_ra(imem_ra), .imem_rb(imem_rb),
    .imem_brx(imem_brx), .imem_ea(imem_ea), .ir_valid(ir_valid),
    .ir_ready(ir_ready), .ir_op(ir_op), .ir_ra(ir_ra), .ir_rb(ir_rb),
    .ir_brx(ir_brx), .ir_ea(ir_ea), .ir_pc(ir_pc),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .halted(halted), .fault(fault)
`ifdef FETCH_PERF_EN
    , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h23;
    mem[8'h01] = 8'hC4;
    mem[8'h02] = 8'h5A;
    mem[8'h10] = 8'h10;
    mem[8'hFE] = 8'hC0;
    mem[8'hFF] = 8'hC0;

    rst_n = 1'b0; run = 1'b0; ir_ready = 1'b1;
    redirect_valid = 1'b0; redirect_addr = 8'h00;
    #12;
    chk("rst_valid", ir_valid, 0);
    chk("rst_pc", imem_addr, 8'h00);
    chk("rst_halted", halted, 0);
    chk("rst_fault", fault, 0);
    chk("rst_irpc", ir_pc, 0);
    rst_n = 1'b1;

    // Idle: nothing loads without run
    tick();
    tick();
    chk("idle_noload", ir_valid, 0);

    run = 1'b1;
    tick();                           // IDLE -> FETCH
    run = 1'b0;
    chk("fetch_noload_yet", ir_valid, 0);
    tick();
    chk("i0_valid", ir_valid, 1);
    chk("i0_op", ir_op, 4'h2);
    chk("i0_pc", ir_pc, 8'h00);
    chk("i0_rb", ir_rb, 2'd3);
    tick();
    chk("i1_op", ir_op, 4'hC);
    chk("i1_pc", ir_pc, 8'h01);
    chk("i1_ea", ir_ea, 8'h5A);
    chk("i1_ra", ir_ra, 2'd1);
    chk("i1_brx", ir_brx, 1);
    chk("pc_after_long", imem_addr, 8'h03);

    // Backpressure for three cycles
    ir_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("stall_valid", ir_valid, 1);
    chk("stall_irpc", ir_pc, 8'h01);
    chk("stall_op", ir_op, 4'hC);
    chk("stall_pc", imem_addr, 8'h03);
`ifdef FETCH_PERF_EN
    chk("perf_stall", perf_stall, 16'd3);
    chk("perf_issued", perf_issued, 16'd1);
`endif

    // Redirect wins over ir_ready
    ir_ready = 1'b1; redirect_valid = 1'b1; redirect_addr = 8'h40;
    tick();
    redirect_valid = 1'b0;
    chk("redir_valid", ir_valid, 0);
    chk("redir_pc", imem_addr, 8'h40);
    tick();
    chk("redir_load_valid", ir_valid, 1);
    chk("redir_load_irpc", ir_pc, 8'h40);

    // Halt opcode at 0x10
    redirect_valid = 1'b1; redirect_addr = 8'h10;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("halt_halted", halted, 1);
    chk("halt_op", ir_op, 4'h1);
    chk("halt_irpc", ir_pc, 8'h10);
    chk("halt_pc", imem_addr, 8'h10);
    tick();
    chk("halt_drop_valid", ir_valid, 0);
    chk("halt_still", halted, 1);
    chk("halt_pc_hold", imem_addr, 8'h10);
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("resume_halted", halted, 0);
    tick();
    chk("resume_irpc", ir_pc, 8'h11);
    chk("resume_valid", ir_valid, 1);

    // Long opcode at 0xFF faults without loading
    redirect_valid = 1'b1; redirect_addr = 8'hFF;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("fault_set", fault, 1);
    chk("fault_halted", halted, 1);
    chk("fault_noload", ir_valid, 0);
    chk("fault_irpc", ir_pc, 8'h11);
    redirect_valid = 1'b1; redirect_addr = 8'h20;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("fault_sticky", fault, 1);
    chk("after_fault_irpc", ir_pc, 8'h20);

    // Two-byte opcode at 0xFE wraps PC to 0x00
    redirect_valid = 1'b1; redirect_addr = 8'hFE;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("wrap_irpc", ir_pc, 8'hFE);
    chk("wrap_ea", ir_ea, 8'hC0);
    chk("wrap_pc", imem_addr, 8'h00);
    tick();
    chk("wrap_next_op", ir_op, 4'h2);
    chk("prerst_pc", imem_addr, 8'h01);

    // Asynchronous reset between edges
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", ir_valid, 0);
    chk("arst_pc", imem_addr, 8'h00);
    chk("arst_fault", fault, 0);
    chk("arst_halted", halted, 0);
    chk("arst_op", ir_op, 0);
`ifdef FETCH_PERF_EN
    chk("arst_perf", perf_issued, 16'd0);
`endif
    #7 rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_idle", ir_valid, 0);
    chk("post_rst_pc", imem_addr, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
